// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - shared types and cause codes for the trap controller
// Purpose: package pack holds the trap FSM state enum, the exception cause
//          constants and the interrupt cause used by trap_controller and trap_priority.
// Ports:   none (package).
package pack;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_VECTOR = 3'd3,
        ST_RETURN = 3'd4
    } trapState_;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'h0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'h2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'h3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'h4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'h6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'hB;

    // Cause reported for the external interrupt (mcauseIrq distinguishes it).
    localparam logic [3:0] CAUSE_EXT_IRQ          = 4'hB;

endpackage

// File: rtl/trap_controller_priority.sv
// rtl/trap_controller_priority.sv - combinational trap event priority selection
// Purpose: picks the single winning event among coincident requests:
//          memory exception > execute exception > decode exception > MRET > interrupt.
// Ports:   mem_exc_valid_i/mem_exc_cause_i, exe_exc_valid_i, dec_exc_valid_i/dec_exc_cause_i,
//          mret_valid_i, irq_req_i (already qualified by enable) ->
//          exc_valid_o/exc_cause_o (winning exception), ret_valid_o, irq_valid_o.
module trap_priority
    import pack::*;
(
    input  logic       mem_exc_valid_i,
    input  logic [3:0] mem_exc_cause_i,
    input  logic       exe_exc_valid_i,
    input  logic       dec_exc_valid_i,
    input  logic [3:0] dec_exc_cause_i,
    input  logic       mret_valid_i,
    input  logic       irq_req_i,
    output logic       exc_valid_o,
    output logic [3:0] exc_cause_o,
    output logic       ret_valid_o,
    output logic       irq_valid_o
);

    always_comb begin
        exc_valid_o = 1'b0;
        exc_cause_o = CAUSE_INSTR_MISALIGNED;
        ret_valid_o = 1'b0;
        irq_valid_o = 1'b0;
        if (mem_exc_valid_i) begin
            exc_valid_o = 1'b1;
            exc_cause_o = mem_exc_cause_i;
        end else if (exe_exc_valid_i) begin
            exc_valid_o = 1'b1;
            exc_cause_o = CAUSE_INSTR_MISALIGNED;
        end else if (dec_exc_valid_i) begin
            // A decode exception also suppresses an MRET in the same slot.
            exc_valid_o = 1'b1;
            exc_cause_o = dec_exc_cause_i;
        end else if (mret_valid_i) begin
            ret_valid_o = 1'b1;
        end else if (irq_req_i) begin
            irq_valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap sequencing FSM: flush, vector, return, interrupt drain
// Purpose: accepts exceptions, MRET and (optionally) interrupts while idle, pulses
//          controlReset for one cycle in FLUSH, then redirects fetch to the trap
//          vector; MRET redirects fetch to mepc without a flush.
//          Interrupt support is compiled only when TRAP_INTERRUPT_EN is defined.
// Ports:   clock, reset (sync, active-high);
//          memExcValid/memExcCause, exeExcValid, decExcValid/decExcCause, mretValid,
//          interrupt, mstatusMIE, pipelineEmpty, mtvec, mepc (inputs);
//          controlReset, mcause, mcauseIrq, redirectValid, redirectPC, busy (outputs).
module trap_controller
    import pack::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        memExcValid,
    input  logic [3:0]  memExcCause,
    input  logic        exeExcValid,
    input  logic        decExcValid,
    input  logic [3:0]  decExcCause,
    input  logic        mretValid,
    input  logic        interrupt,
    input  logic        mstatusMIE,
    input  logic        pipelineEmpty,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        controlReset,
    output logic [3:0]  mcause,
    output logic        mcauseIrq,
    output logic        redirectValid,
    output logic [31:0] redirectPC,
    output logic        busy
);

    trapState_  state_q, state_d;
    logic [3:0] mcause_q, mcause_d;
    logic       mcause_irq_q, mcause_irq_d;

    logic       irq_req;
    logic       exc_valid;
    logic [3:0] exc_cause;
    logic       ret_valid;
    logic       irq_valid;
    logic       unused_inputs;

`ifdef TRAP_INTERRUPT_EN
    assign irq_req       = interrupt & mstatusMIE;
    assign unused_inputs = ^mtvec[1:0];
`else
    assign irq_req       = 1'b0;
    assign unused_inputs = ^{interrupt, mstatusMIE, pipelineEmpty, mtvec[1:0]};
`endif

    trap_priority u_priority (
        .mem_exc_valid_i (memExcValid),
        .mem_exc_cause_i (memExcCause),
        .exe_exc_valid_i (exeExcValid),
        .dec_exc_valid_i (decExcValid),
        .dec_exc_cause_i (decExcCause),
        .mret_valid_i    (mretValid),
        .irq_req_i       (irq_req),
        .exc_valid_o     (exc_valid),
        .exc_cause_o     (exc_cause),
        .ret_valid_o     (ret_valid),
        .irq_valid_o     (irq_valid)
    );

    always_comb begin
        state_d      = state_q;
        mcause_d     = mcause_q;
        mcause_irq_d = mcause_irq_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    state_d      = ST_FLUSH;
                    mcause_d     = exc_cause;
                    mcause_irq_d = 1'b0;
                end else if (ret_valid) begin
                    state_d = ST_RETURN;
                end else if (irq_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
`ifdef TRAP_INTERRUPT_EN
                // An exception overtakes the pending interrupt; the interrupt
                // is dropped and must be re-raised by its source.
                if (exc_valid) begin
                    state_d      = ST_FLUSH;
                    mcause_d     = exc_cause;
                    mcause_irq_d = 1'b0;
                end else if (pipelineEmpty) begin
                    state_d      = ST_FLUSH;
                    mcause_d     = CAUSE_EXT_IRQ;
                    mcause_irq_d = 1'b1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_FLUSH:  state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_IDLE;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mcause_q     <= 4'h0;
            mcause_irq_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcause_q     <= mcause_d;
            mcause_irq_q <= mcause_irq_d;
        end
    end

    always_comb begin
        controlReset  = (state_q == ST_FLUSH);
        redirectValid = (state_q == ST_VECTOR) || (state_q == ST_RETURN);
        busy          = (state_q != ST_IDLE);
        redirectPC    = 32'h0;
        if (state_q == ST_VECTOR) begin
            redirectPC = {mtvec[31:2], 2'b00};
        end else if (state_q == ST_RETURN) begin
            redirectPC = mepc;
        end
    end

    assign mcause    = mcause_q;
    assign mcauseIrq = mcause_irq_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        memExcValid;
    logic [3:0]  memExcCause;
    logic        exeExcValid;
    logic        decExcValid;
    logic [3:0]  decExcCause;
    logic        mretValid;
    logic        interrupt;
    logic        mstatusMIE;
    logic        pipelineEmpty;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        controlReset;
    logic [3:0]  mcause;
    logic        mcauseIrq;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        busy;

    trap_controller dut (
        .clock         (clock),
        .reset         (reset),
        .memExcValid   (memExcValid),
        .memExcCause   (memExcCause),
        .exeExcValid   (exeExcValid),
        .decExcValid   (decExcValid),
        .decExcCause   (decExcCause),
        .mretValid     (mretValid),
        .interrupt     (interrupt),
        .mstatusMIE    (mstatusMIE),
        .pipelineEmpty (pipelineEmpty),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .controlReset  (controlReset),
        .mcause        (mcause),
        .mcauseIrq     (mcauseIrq),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .busy          (busy)
    );

    always #5 clock = ~clock;

`ifdef TRAP_INTERRUPT_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each cycle must look like, as a list of upcoming
    // visible cycles. pcsel: 0 none, 1 trap vector, 2 return address.
    typedef struct {
        bit busy;
        bit cr;
        bit rv;
        int pcsel;
    } view_t;

    function automatic view_t mk(bit b, bit c, bit r, int p);
        view_t v;
        v.busy = b; v.cr = c; v.rv = r; v.pcsel = p;
        return v;
    endfunction

    view_t      cur;
    view_t      upcoming[$];
    bit         draining  = 1'b0;
    bit         model_on  = 1'b0;
    logic [3:0] m_cause   = 4'h0;
    bit         m_irq     = 1'b0;

    function automatic void take_trap(input logic [3:0] c, input bit irq);
        cur = mk(1, 1, 0, 0);
        upcoming.delete();
        upcoming.push_back(mk(1, 0, 1, 1));
        m_cause  = c;
        m_irq    = irq;
        draining = 1'b0;
    endfunction

    initial begin
        cur = mk(0, 0, 0, 0);
        forever begin
            @(posedge clock);
            if (reset) begin
                model_on = 1'b1;
                cur      = mk(0, 0, 0, 0);
                upcoming.delete();
                draining = 1'b0;
                m_cause  = 4'h0;
                m_irq    = 1'b0;
            end else if (model_on) begin
                bit         e;
                logic [3:0] c;
                e = 1'b1;
                if (memExcValid)      c = memExcCause;
                else if (exeExcValid) c = 4'h0;
                else if (decExcValid) c = decExcCause;
                else begin e = 1'b0; c = 4'h0; end
                if (draining) begin
                    if (e)                  take_trap(c, 1'b0);
                    else if (pipelineEmpty) take_trap(4'hB, 1'b1);
                end else if (cur.busy) begin
                    cur = (upcoming.size() > 0) ? upcoming.pop_front() : mk(0, 0, 0, 0);
                end else if (e) begin
                    take_trap(c, 1'b0);
                end else if (mretValid) begin
                    cur = mk(1, 0, 1, 2);
                end else if (IRQ_EN && interrupt && mstatusMIE) begin
                    draining = 1'b1;
                    cur      = mk(1, 0, 0, 0);
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_on && !reset) begin
                logic [31:0] exp_pc;
                exp_pc = (cur.pcsel == 1) ? {mtvec[31:2], 2'b00} :
                         (cur.pcsel == 2) ? mepc : 32'h0;
                chk("m_controlReset",  {31'h0, controlReset},  {31'h0, cur.cr});
                chk("m_redirectValid", {31'h0, redirectValid}, {31'h0, cur.rv});
                chk("m_busy",          {31'h0, busy},          {31'h0, cur.busy});
                chk("m_redirectPC",    redirectPC,             exp_pc);
                chk("m_mcause",        {28'h0, mcause},        {28'h0, m_cause});
                chk("m_mcauseIrq",     {31'h0, mcauseIrq},     {31'h0, m_irq});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_in();
        memExcValid = 0; memExcCause = 4'h4; exeExcValid = 0;
        decExcValid = 0; decExcCause = 4'h2; mretValid = 0;
        interrupt = 0; mstatusMIE = 0; pipelineEmpty = 0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_cr"},   {31'h0, controlReset},  32'h0);
        chk({name, "_rv"},   {31'h0, redirectValid}, 32'h0);
        chk({name, "_busy"}, {31'h0, busy},          32'h0);
        chk({name, "_cause"},{28'h0, mcause},        32'h0);
        chk({name, "_irq"},  {31'h0, mcauseIrq},     32'h0);
        chk({name, "_pc"},   redirectPC,             32'h0);
    endtask

    int pulses;

    initial begin
        // Reset with garbage on every input: none of it may be taken.
        reset = 1; memExcValid = 1; memExcCause = 4'h6; exeExcValid = 1;
        decExcValid = 1; decExcCause = 4'h3; mretValid = 1; interrupt = 1;
        mstatusMIE = 1; pipelineEmpty = 1; mtvec = 32'h80; mepc = 32'h1234;
        tick(); tick(); tick();
        chk_all_zero("reset");
        clear_in();
        reset = 0;
        tick(); tick();

        // Decode exception, cause 2, mtvec 0x80.
        decExcValid = 1; decExcCause = 4'h2; mtvec = 32'h80;
        tick();
        decExcValid = 0;
        chk("dec_flush_cr",    {31'h0, controlReset}, 32'h1);
        chk("dec_flush_cause", {28'h0, mcause},       32'h2);
        chk("dec_flush_irq",   {31'h0, mcauseIrq},    32'h0);
        tick();
        chk("dec_vec_rv", {31'h0, redirectValid}, 32'h1);
        chk("dec_vec_pc", redirectPC,             32'h80);
        chk("dec_vec_cr", {31'h0, controlReset},  32'h0);
        tick();
        chk("dec_idle_busy",  {31'h0, busy},   32'h0);
        chk("dec_hold_cause", {28'h0, mcause}, 32'h2);

        // Memory (cause 6) and execute exceptions together.
        memExcValid = 1; memExcCause = 4'h6; exeExcValid = 1;
        tick();
        clear_in();
        chk("mem_cause", {28'h0, mcause}, 32'h6);
        pulses = 32'(controlReset);
        for (int i = 0; i < 5; i++) begin tick(); pulses += 32'(controlReset); end
        chk("mem_one_pulse", pulses, 32'h1);

        // MRET to 0x1234.
        mretValid = 1; mepc = 32'h1234;
        tick();
        mretValid = 0;
        chk("mret_rv", {31'h0, redirectValid}, 32'h1);
        chk("mret_pc", redirectPC,             32'h1234);
        pulses = 32'(controlReset);
        for (int i = 0; i < 3; i++) begin tick(); pulses += 32'(controlReset); end
        chk("mret_no_cr", pulses, 32'h0);

        // MRET together with a decode exception: the exception wins.
        mretValid = 1; decExcValid = 1; decExcCause = 4'h3;
        tick();
        clear_in();
        chk("mret_dec_cr",    {31'h0, controlReset}, 32'h1);
        chk("mret_dec_cause", {28'h0, mcause},       32'h3);
        tick(); tick();

        // Reset while in FLUSH.
        memExcValid = 1; memExcCause = 4'h4;
        tick();
        chk("rst_in_flush_cr", {31'h0, controlReset}, 32'h1);
        reset = 1;
        tick();
        reset = 0;
        clear_in();
        chk_all_zero("rst_mid");
        tick();

        // Second exception while in VECTOR is ignored.
        memExcValid = 1; memExcCause = 4'h4;
        tick();
        memExcCause = 4'h6;
        tick();
        chk("vec_rv",    {31'h0, redirectValid}, 32'h1);
        tick();
        clear_in();
        chk("vec_ign_cr",    {31'h0, controlReset}, 32'h0);
        chk("vec_ign_busy",  {31'h0, busy},         32'h0);
        chk("vec_ign_cause", {28'h0, mcause},       32'h4);

`ifdef TRAP_INTERRUPT_EN
        // Interrupt drains until the pipeline is empty.
        interrupt = 1; mstatusMIE = 1; pipelineEmpty = 0;
        tick();
        interrupt = 0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_busy", {31'h0, busy},         32'h1);
            chk("drain_cr",   {31'h0, controlReset}, 32'h0);
            tick();
        end
        chk("drain_busy_last", {31'h0, busy}, 32'h1);
        pipelineEmpty = 1;
        tick();
        clear_in();
        chk("irq_cr",    {31'h0, controlReset}, 32'h1);
        chk("irq_cause", {28'h0, mcause},       32'hB);
        chk("irq_flag",  {31'h0, mcauseIrq},    32'h1);
        tick(); tick();
`else
        // Without interrupt support the request is inert.
        interrupt = 1; mstatusMIE = 1; pipelineEmpty = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noirq_busy", {31'h0, busy}, 32'h0);
        end
        clear_in();
        tick();
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            memExcValid   = ($urandom_range(0, 11) == 0);
            memExcCause   = $urandom_range(0, 1) ? 4'h6 : 4'h4;
            exeExcValid   = ($urandom_range(0, 11) == 0);
            decExcValid   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0: decExcCause = 4'h2;
                1: decExcCause = 4'h3;
                default: decExcCause = 4'hB;
            endcase
            mretValid     = ($urandom_range(0, 7) == 0);
            interrupt     = ($urandom_range(0, 5) == 0);
            mstatusMIE    = $urandom_range(0, 1);
            pipelineEmpty = ($urandom_range(0, 2) == 0);
            mtvec         = $urandom;
            mepc          = $urandom;
            tick();
        end
        reset = 0;
        clear_in();
        tick(); tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports: memExcValid  in  1  memory-stage exception; memExcCause  in  4  cause, 4h4 or 4h6.
REQ-003 SHALL have ports: exeExcValid  in  1  execute-stage exception (cause 4h0); decExcValid  in  1  decode-stage exception; decExcCause  in  4  cause, 4h2, 4h3 or 4hB.
REQ-004 SHALL have ports: mretValid  in  1  MRET in decode-execute; interrupt  in  1  external interrupt level; mstatusMIE  in  1  global interrupt enable; pipelineEmpty  in  1  no valid instruction in flight.
REQ-005 SHALL have ports: mtvec  in  32  trap vector; mepc  in  32  return address.
REQ-006 SHALL have ports: controlReset  out  1  flush pulse to pipeline and CSR file; mcause  out  4  captured cause; mcauseIrq  out  1  cause is interrupt.
REQ-007 SHALL have ports: redirectValid  out  1  fetch redirect strobe; redirectPC  out  32  redirect target; busy  out  1  front-end stall.

Function
REQ-008 SHALL implement states IDLE, DRAIN, FLUSH, VECTOR and RETURN.
REQ-009 SHALL accept new events only in IDLE; all requests in other states are ignored.
REQ-010 SHALL prioritise memExcValid over exeExcValid over decExcValid over mretValid over interrupt when events coincide in IDLE.
REQ-011 SHALL, on a winning exception in cycle N, latch its cause and enter FLUSH at N+1.
REQ-012 SHALL hold controlReset=1 only while in FLUSH, for exactly one cycle, with mcause valid in that cycle.
REQ-013 SHALL go FLUSH->VECTOR, driving redirectValid=1 and redirectPC={mtvec[31:2],2b00} for one cycle, then return to IDLE.
REQ-014 SHALL, on a winning mretValid, enter RETURN, drive redirectValid=1 and redirectPC=mepc for one cycle, then return to IDLE; controlReset stays 0.
REQ-015 SHALL ignore mretValid when decExcValid is set in the same cycle.
REQ-016 SHALL assert busy in every non-IDLE state.
REQ-017 SHALL drive mcauseIrq=0 for every exception cause.
REQ-018 SHALL hold mcause at its last latched value outside FLUSH.

Reset
REQ-019 SHALL, on reset (including mid-sequence), enter IDLE with controlReset=0, redirectValid=0, busy=0, mcause=4h0, mcauseIrq=0, redirectPC=32h0.
REQ-020 SHALL ignore every input during the reset cycle.

Configuration
REQ-021 SHALL compile interrupt support under macro TRAP_INTERRUPT_EN.
REQ-022 With TRAP_INTERRUPT_EN defined, SHALL move IDLE->DRAIN when interrupt && mstatusMIE and no higher-priority event is present.
REQ-023 With TRAP_INTERRUPT_EN defined, SHALL hold busy in DRAIN until pipelineEmpty, then enter FLUSH with mcause=4hB and mcauseIrq=1.
REQ-024 With TRAP_INTERRUPT_EN defined, SHALL abandon DRAIN for FLUSH if an exception arrives during DRAIN, with the exception taking the cause.
REQ-025 With TRAP_INTERRUPT_EN undefined, SHALL ignore interrupt, mstatusMIE and pipelineEmpty, and SHALL never enter DRAIN.

Structure
REQ-026 SHALL place the state enum (trapState_) and cause constants (CAUSE_INSTR_MISALIGNED=0, CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_LOAD_MISALIGNED=4, CAUSE_STORE_MISALIGNED=6, CAUSE_ECALL_M=0xB) in package pack.
REQ-027 SHALL implement the combinational selection of REQ-010 in one sub-module, trap_priority.

Verification
REQ-028 Bench SHALL cover: decExcValid, cause 4h2, in cycle 10 with mtvec=0x80 -> controlReset=1 and mcause=2 in cycle 11; redirectValid=1 and redirectPC=0x80 in cycle 12.
REQ-029 Bench SHALL cover: memExcValid (cause 4h6) with exeExcValid in the same cycle -> mcause=6, exactly one controlReset pulse.
REQ-030 Bench SHALL cover: mretValid with mepc=0x1234 -> redirectPC=0x1234 next cycle, controlReset never asserted.
REQ-031 Bench SHALL cover: TRAP_INTERRUPT_EN defined, interrupt=1, MIE=1, pipelineEmpty held 0 for 3 cycles -> busy held in DRAIN; on pipelineEmpty=1, FLUSH with mcause=0xB and mcauseIrq=1.
REQ-032 Bench SHALL cover: reset asserted in FLUSH -> next cycle IDLE with all outputs 0; a second exception during VECTOR -> ignored.
